// File: rtl/alu_sequencer_if.sv
// Bundle of instruction, preload, external-ALU and status signals of the
// ALU sequencer. The sequencer takes the slave view, its environment the master.
interface alu_sequencer_if;
    logic       InValid;
    logic [7:0] Instr;
    logic       InReady;
    logic       LoadEn;
    logic [1:0] LoadAddr;
    logic [3:0] LoadData;
    logic [3:0] AluX;
    logic [3:0] AluY;
    logic [1:0] AluOp;
    logic [3:0] AluO;
    logic       Done;
    logic [3:0] Result;
    logic       Zero;
    logic [1:0] DbgAddr;
    logic [3:0] DbgData;

    modport slave (
        input  InValid, Instr, LoadEn, LoadAddr, LoadData, AluO, DbgAddr,
        output InReady, AluX, AluY, AluOp, Done, Result, Zero, DbgData
    );

    modport master (
        output InValid, Instr, LoadEn, LoadAddr, LoadData, AluO, DbgAddr,
        input  InReady, AluX, AluY, AluOp, Done, Result, Zero, DbgData
    );
endinterface

// File: rtl/alu_sequencer.sv
// Three-state sequencer: issues one instruction to an external combinational
// ALU, captures its result, then writes it back into a small register file.
module alu_sequencer #(
    parameter int NREG = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] instr_p0;
    logic [3:0] res_p1;
    logic [3:0] regs [NREG];

    logic       accept;
    logic       load_wr;
    logic       vld_p0;
    logic       vld_p1;

    logic [1:0] op_p0;
    logic [1:0] rd_p0;
    logic [1:0] rx_p0;
    logic [1:0] ry_p0;

    function automatic logic is_zero(input logic [3:0] v);
        return (v == 4'd0);
    endfunction

    assign op_p0 = instr_p0[7:6];
    assign rd_p0 = instr_p0[5:4];
    assign rx_p0 = instr_p0[3:2];
    assign ry_p0 = instr_p0[1:0];

    assign bus.DbgData = regs[bus.DbgAddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A preload in IDLE blocks acceptance, so the two never share an edge.
    always_comb begin
        bus.InReady = 1'b0;
        bus.AluX    = 4'd0;
        bus.AluY    = 4'd0;
        bus.AluOp   = 2'd0;
        accept      = 1'b0;
        load_wr     = 1'b0;
        vld_p0      = 1'b0;
        vld_p1      = 1'b0;
        case (state)
            IDLE: begin
                bus.InReady = !bus.LoadEn;
                load_wr     = bus.LoadEn;
                accept      = bus.InValid && !bus.LoadEn;
            end
            ISSUE: begin
                bus.AluX  = regs[rx_p0];
                bus.AluY  = regs[ry_p0];
                bus.AluOp = op_p0;
                vld_p0    = 1'b1;
            end
            WB: begin
                vld_p1 = 1'b1;
            end
            default: ;
        endcase
    end

    // Stage p0 -> p1: latch instruction, capture ALU result, write back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p0   <= 8'd0;
            res_p1     <= 4'd0;
            bus.Result <= 4'd0;
            bus.Zero   <= 1'b0;
            bus.Done   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 4'd0;
            end
        end else begin
            bus.Done <= vld_p1;
            if (accept) begin
                instr_p0 <= bus.Instr;
            end
            if (vld_p0) begin
                res_p1 <= bus.AluO;
            end
            if (load_wr) begin
                regs[bus.LoadAddr] <= bus.LoadData;
            end
            if (vld_p1) begin
                regs[rd_p0] <= res_p1;
                bus.Result  <= res_p1;
                bus.Zero    <= is_zero(res_p1);
            end
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter NREG, default 4, meaning number of 4-bit registers; fixed at 4 (2-bit addresses).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port InValid  input  1  instruction offered.
REQ-005 SHALL have port Instr  input  8  instruction: [7:6] Op, [5:4] Rd, [3:2] Rx, [1:0] Ry.
REQ-006 SHALL have port InReady  output  1  sequencer can accept an instruction this cycle.
REQ-007 SHALL have port LoadEn  input  1  register preload request.
REQ-008 SHALL have port LoadAddr  input  2  preload target register.
REQ-009 SHALL have port LoadData  input  4  preload value.
REQ-010 SHALL have port AluX  output  4  ALU operand X.
REQ-011 SHALL have port AluY  output  4  ALU operand Y.
REQ-012 SHALL have port AluOp  output  2  ALU opcode: 00 add, 01 sub, 10 and, 11 not X.
REQ-013 SHALL have port AluO  input  4  ALU result, combinational from AluX/AluY/AluOp.
REQ-014 SHALL have port Done  output  1  one-cycle pulse, writeback completed.
REQ-015 SHALL have port Result  output  4  last written-back value.
REQ-016 SHALL have port Zero  output  1  last written-back value was 0.
REQ-017 SHALL have port DbgAddr  input  2 and DbgData  output  4; DbgData is R[DbgAddr], combinational.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WB; IDLE->ISSUE on accept, ISSUE->WB always, WB->IDLE always.
REQ-019 SHALL assert InReady only in IDLE with LoadEn low.
REQ-020 SHALL accept an instruction on a rising edge where InValid & InReady; Instr latched that edge; Instr ignored otherwise.
REQ-021 SHALL, in ISSUE only, drive AluX=R[Rx], AluY=R[Ry], AluOp=Op from the latched instruction; outside ISSUE drive all three to 0.
REQ-022 SHALL capture AluO into an internal result register on the edge leaving ISSUE.
REQ-023 SHALL, on the edge leaving WB, write captured value to R[Rd], update Result and Zero, and set Done high for exactly the following cycle.
REQ-024 SHALL give accept-to-Done latency of 3 cycles and allow a new accept in the same cycle Done is high (throughput one instruction per 3 cycles).
REQ-025 SHALL treat all arithmetic modulo 16; no carry/borrow output; 4-bit AluO stored unmodified.
REQ-026 SHALL permit Rd equal to Rx or Ry; operands read in ISSUE are pre-writeback values; a following instruction sees the new value (no hazard possible).
REQ-027 SHALL write LoadData to R[LoadAddr] on an edge with LoadEn high and state IDLE; LoadEn in ISSUE or WB ignored (no write, no queuing).
REQ-028 SHALL give LoadEn priority over InValid in IDLE: no instruction accepted that cycle.
REQ-029 SHALL not change Result, Zero or Done on a preload.
REQ-030 SHALL hold InValid/Instr semantics stateless: a withdrawn InValid before accept leaves no effect.

Reset
REQ-031 SHALL, while rst_n low, immediately force state IDLE, all R[i]=0, result register 0, Result=0, Zero=0, Done=0, latched instruction 0.
REQ-032 SHALL abort any in-flight instruction on reset with no register writeback and no Done pulse.
REQ-033 SHALL present InReady=1 (LoadEn low) and AluX/AluY/AluOp=0 in the first cycle after rst_n deasserts.

Verification
REQ-034 SHALL cover: preload R1=5, R2=3; Instr 00_00_01_10 (R0=R1+R2) -> AluX=5, AluY=3, AluOp=00 in ISSUE; Done 3 cycles after accept; R0=8, Result=8, Zero=0.
REQ-035 SHALL cover: R1=3, R2=5, sub into R3 -> R3=14 (wrap); then R1 minus R1 into R0 -> R0=0, Zero=1.
REQ-036 SHALL cover: R1=12, and (R1,R1) into R1 then not R1 into R2 -> R1=12, R2=3; Rd=Rx case reads old value.
REQ-037 SHALL cover: LoadEn and InValid high together in IDLE -> load performed, InReady=0, instruction accepted next cycle; LoadEn during ISSUE -> target register unchanged.
REQ-038 SHALL cover: rst_n pulsed low during ISSUE of an add into R0 -> no Done, R0=0, InReady=1 after release.
REQ-039 SHALL cover: InValid held high for 3 back-to-back instructions -> accepts exactly every 3rd cycle, three Done pulses, correct final register values.
